// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate stage.
//   mac_state_e : controller states (ACCUM collects terms, HOLD presents a result)
//   OP_W        : operand width of the multiplier
//   PROD_W      : product width of the multiplier
//   ACC_W_DEF   : default accumulator / result width
//   CNT_W_DEF   : default term-counter width
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_e;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mult_accumulate_stage_mult.sv
// Wallace_Tree_Multiplier_8x8: purely combinational unsigned 8x8 multiplier.
// The eight partial-product rows are reduced with carry-save (3:2) layers
// 8 -> 6 -> 4 -> 3 -> 2 and a single carry-propagate add forms the product.
// Ports:
//   A       in  OP_W    unsigned multiplicand
//   B       in  OP_W    unsigned multiplier
//   Product out PROD_W  A*B
module Wallace_Tree_Multiplier_8x8
  import mac_pkg::*;
(
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] Product
);

  logic [PROD_W-1:0] pp [OP_W];
  logic [PROD_W-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  // Row-wise 3:2 compressor. The carry out of bit PROD_W-1 is dropped; the
  // true product always fits in PROD_W bits, so this is exact.
  function automatic void csa(input  logic [PROD_W-1:0] x,
                              input  logic [PROD_W-1:0] y,
                              input  logic [PROD_W-1:0] z,
                              output logic [PROD_W-1:0] s,
                              output logic [PROD_W-1:0] c);
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      pp[i] = B[i] ? ({{(PROD_W-OP_W){1'b0}}, A} << i) : '0;
    end
  end

  always_comb begin
    csa(pp[0], pp[1], pp[2], s0, c0);
    csa(pp[3], pp[4], pp[5], s1, c1);
    csa(s0, c0, s1, s2, c2);
    csa(c1, pp[6], pp[7], s3, c3);
    csa(s2, c2, s3, s4, c4);
    csa(s4, c4, c3, s5, c5);
  end

  assign Product = s5 + c5;

endmodule

// File: rtl/mult_accumulate_stage.sv
// mult_accumulate_stage: sums a burst of 8x8 products into an ACC_W-bit
// accumulator and presents one result per burst over valid/ready.
// Build option: ACC_SATURATE_EN -- when defined the accumulator clamps to
// 2^ACC_W-1 on overflow for the rest of the burst; otherwise it wraps.
// out_ovf marks the overflow in both builds.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand pair present
//   in_ready   out  block can accept an operand pair (ACCUM state)
//   in_a, in_b in   unsigned 8-bit operands
//   in_last    in   pair closes the burst
//   out_valid  out  burst result held on out_*
//   out_ready  in   consumer accepts the result
//   out_acc    out  ACC_W-bit burst sum
//   out_count  out  CNT_W-bit term count (saturating)
//   out_ovf    out  accumulator overflowed during the burst
module mult_accumulate_stage
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  mac_state_e        state_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q;
  logic [ACC_W-1:0]  out_acc_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              out_ovf_q;

  logic [PROD_W-1:0] product;
  logic [ACC_W:0]    sum;
  logic              accept;

`ifdef ACC_SATURATE_EN
  // Once clamped, the accumulator stays at full scale until the burst ends.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s,
                                               input logic           clamped);
    if (clamped || s[ACC_W]) return '1;
    return s[ACC_W-1:0];
  endfunction
`endif

  Wallace_Tree_Multiplier_8x8 u_mult (
    .A       (in_a),
    .B       (in_b),
    .Product (product)
  );

  assign in_ready = (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  // One extra bit on the sum exposes the carry out of the accumulator.
  always_comb begin
    sum   = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, product};
    ovf_d = ovf_q | sum[ACC_W];
`ifdef ACC_SATURATE_EN
    acc_d = sat_acc(sum, ovf_q);
`else
    acc_d = sum[ACC_W-1:0];
`endif
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (in_last) begin
              // Closing term: publish totals including this term and start
              // the next burst from zero.
              out_acc_q   <= acc_d;
              out_count_q <= cnt_d;
              out_ovf_q   <= ovf_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult_accumulate_stage.sv
module tb_mult_accumulate_stage;

  localparam int ACC_W = 24;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a, in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  mult_accumulate_stage #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint acc;
    longint cnt;
    logic   ovf;
  } exp_t;

  exp_t   q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_pushed = 0;
  int     n_results = 0;
  longint m_total = 0;
  int     m_cnt = 0;
  bit     rand_rdy = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: burst result from the true (unbounded) sum of products.
  function automatic exp_t make_exp(input longint total, input int n);
    exp_t   e;
    longint lim = longint'(1) << ACC_W;
    e.ovf = (total >= lim);
`ifdef ACC_SATURATE_EN
    e.acc = e.ovf ? lim - 1 : total;
`else
    e.acc = total % lim;
`endif
    e.cnt = (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last,
                      output int waits);
    exp_t e;
    waits = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready) begin
      tick();
      waits++;
      if (waits > 1000) begin
        $display("FAIL send_timeout: in_ready stuck at %0d, expected 1", in_ready);
        $fatal(1, "bench stopped");
      end
    end
    tick();
    m_total += longint'(a) * longint'(b);
    m_cnt++;
    if (last) begin
      e = make_exp(m_total, m_cnt);
      q.push_back(e);
      n_pushed++;
      m_total = 0;
      m_cnt = 0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    m_total = 0; m_cnt = 0;
    n_pushed -= q.size();
    q.delete();
  endtask

  // Monitor: a result is consumed at the edge following a negedge where
  // out_valid && out_ready, so each result is seen exactly once here.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_results++;
      if (q.size() == 0) begin
        check("unexpected_result", out_acc, -1);
      end else begin
        e = q.pop_front();
        check("res_acc", out_acc, e.acc);
        check("res_count", out_count, e.cnt);
        check("res_ovf", out_ovf, e.ovf);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int w;
    logic [7:0] ra, rb;
    in_a = 0; in_b = 0; in_last = 0; in_valid = 0; out_ready = 0; rst_n = 0;
    tick(); tick();
    do_reset();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // Three-term burst, result held for inspection.
    send(8'd3, 8'd5, 1'b0, w);
    send(8'd10, 8'd10, 1'b0, w);
    send(8'd255, 8'd1, 1'b1, w);
    check("b3_valid_latency", out_valid, 1);
    check("b3_acc", out_acc, 370);
    check("b3_count", out_count, 3);
    check("b3_ovf", out_ovf, 0);
    check("b3_in_ready_hold", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b3_valid_drop", out_valid, 0);
    check("b3_in_ready_back", in_ready, 1);

    // Single-term burst with back-pressure.
    send(8'd255, 8'd255, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_acc", out_acc, 65025);
      check("hold_count", out_count, 1);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 259 maximal terms: counter saturation and overflow.
    for (int i = 0; i < 258; i++) send(8'd255, 8'd255, 1'b0, w);
    send(8'd255, 8'd255, 1'b1, w);
`ifdef ACC_SATURATE_EN
    check("big_acc", out_acc, 16777215);
`else
    check("big_acc", out_acc, 64259);
`endif
    check("big_count", out_count, 255);
    check("big_ovf", out_ovf, 1);
    out_ready = 1'b1;
    tick();

    // Back-to-back bursts with out_ready tied high: one bubble per burst.
    send(8'd1, 8'd2, 1'b0, w);
    send(8'd3, 8'd4, 1'b1, w);
    check("b2b_in_ready_bubble", in_ready, 0);
    send(8'd5, 8'd6, 1'b0, w);
    check("b2b_bubble_cycles", w, 1);
    send(8'd7, 8'd1, 1'b1, w);
    check("b2b_second_acc", out_acc, 37);

    // Reset in the middle of a burst.
    tick();
    for (int i = 0; i < 4; i++) send(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0, w);
    do_reset();
    send(8'd2, 8'd2, 1'b1, w);
    check("rst_mid_acc", out_acc, 4);
    check("rst_mid_count", out_count, 1);
    check("rst_mid_ovf", out_ovf, 0);

    // Randomised traffic on both sides.
    rand_rdy = 1;
    for (int bst = 0; bst < 40; bst++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int t = 0; t < len; t++) begin
        repeat ($urandom_range(0, 2)) begin
          in_a = 8'($urandom); in_b = 8'($urandom); in_last = 1'($urandom);
          tick();
        end
        ra = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
        send(ra, rb, (t == len - 1), w);
      end
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) tick();
    check("drain_queue_empty", q.size(), 0);
    check("result_count", n_results, n_pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
